// File: rtl/message_streamer.sv
// Reads a message out of a synchronous-read ROM and offers it byte by byte on a
// valid/ready stream, optionally repeating after an idle gap.
module message_streamer #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned msg_len    = 512,
    parameter int unsigned repeat_msg = 0,
    parameter int unsigned gap_cycles = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [addr_width-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned gap_w = (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1;
    localparam logic [addr_width-1:0] last_addr = addr_width'(msg_len - 1);
    localparam logic [gap_w-1:0] gap_last = gap_w'((gap_cycles > 0) ? gap_cycles - 1 : 0);
    localparam logic do_repeat = (repeat_msg != 0);
    localparam logic has_gap   = (gap_cycles > 0);

    if (msg_len == 0 || 64'(msg_len) > (64'd1 << addr_width)) begin : g_bad_len
        $error("message_streamer: msg_len must be in 1..2**addr_width");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [gap_w-1:0]      gap_cnt, gap_cnt_nxt;
    logic [addr_width-1:0] rom_addr_nxt;
    logic [7:0]            tx_data_nxt;
    logic                  tx_valid_nxt;
    logic                  done_nxt;
    logic                  busy_nxt;
    logic                  handshake;
    logic                  at_last;
    logic                  gap_over;

    assign handshake = tx_valid & tx_ready;
    assign at_last   = (rom_addr == last_addr);
    assign gap_over  = (gap_cnt == gap_last);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND: begin
                if (handshake) begin
                    if (!at_last)               state_nxt = FETCH;
                    else if (do_repeat && has_gap) state_nxt = GAP;
                    else if (do_repeat)         state_nxt = FETCH;
                    else                        state_nxt = IDLE;
                end
            end
            GAP:     if (gap_over) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the gap counter
    always_comb begin
        rom_addr_nxt = rom_addr;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        gap_cnt_nxt  = gap_cnt;
        done_nxt     = 1'b0;
        busy_nxt     = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                rom_addr_nxt = '0;
                gap_cnt_nxt  = '0;
            end
            CAPTURE: begin
                tx_data_nxt  = rom_data;
                tx_valid_nxt = 1'b1;
            end
            SEND: begin
                if (handshake) begin
                    tx_valid_nxt = 1'b0;
                    if (at_last) begin
                        done_nxt     = 1'b1;
                        rom_addr_nxt = '0;
                    end else begin
                        rom_addr_nxt = rom_addr + addr_width'(1);
                    end
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_over ? '0 : gap_cnt + gap_w'(1);
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset aborts any message in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_addr <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            rom_addr <= rom_addr_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
            gap_cnt  <= gap_cnt_nxt;
        end
    end

endmodule
